// File: rtl/board_access_ctrl.sv
// Single owner of the board RAM port: runs the zero-fill sweep, then round-robins game and display accesses.
// Grants drive the RAM combinationally; read data returns one cycle later with a matching rvalid.
module board_access_ctrl #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int BUS_W  = 4,
  parameter int XW     = 3,
  parameter int YW     = 3,
  parameter int AW     = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_req,
  output logic             clear_busy,
  input  logic             g_req,
  input  logic             g_we,
  input  logic [XW-1:0]    g_x,
  input  logic [YW-1:0]    g_y,
  input  logic [BUS_W-1:0] g_wdata,
  output logic             g_gnt,
  output logic             g_rvalid,
  output logic [BUS_W-1:0] g_rdata,
  input  logic             d_req,
  input  logic [XW-1:0]    d_x,
  input  logic [YW-1:0]    d_y,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [BUS_W-1:0] d_rdata,
  output logic             oob_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [BUS_W-1:0] mem_wdata,
  input  logic [BUS_W-1:0] mem_rdata
);

  localparam int CELLS = WIDTH * HEIGHT;

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
  logic          rr_ptr_reg, rr_ptr_next;   // 0: game has priority, 1: display
  logic          g_pend_reg, g_pend_next;
  logic          g_oob_reg, g_oob_next;
  logic          d_pend_reg, d_pend_next;
  logic          d_oob_reg, d_oob_next;

  logic          g_oob, d_oob;
  logic [AW-1:0] g_addr, d_addr;

  assign g_oob  = (32'(g_x) >= WIDTH) || (32'(g_y) >= HEIGHT);
  assign d_oob  = (32'(d_x) >= WIDTH) || (32'(d_y) >= HEIGHT);
  assign g_addr = AW'(AW'(g_y) * AW'(WIDTH) + AW'(g_x));
  assign d_addr = AW'(AW'(d_y) * AW'(WIDTH) + AW'(d_x));

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    rr_ptr_next  = rr_ptr_reg;
    g_pend_next  = 1'b0;
    g_oob_next   = 1'b0;
    d_pend_next  = 1'b0;
    d_oob_next   = 1'b0;
    g_gnt        = 1'b0;
    d_gnt        = 1'b0;
    oob_err      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_reg)
      CLEAR: begin
        // Held off while reset is asserted so the RAM sees no writes during reset.
        mem_en   = reset_n;
        mem_we   = reset_n;
        mem_addr = clr_cnt_reg;
        if (clr_cnt_reg == AW'(CELLS - 1)) begin
          state_next   = SERVE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      SERVE: begin
        if (clear_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end else if (g_req && (!d_req || !rr_ptr_reg)) begin
          g_gnt       = 1'b1;
          rr_ptr_next = 1'b1;
          oob_err     = g_oob;
          mem_en      = !g_oob;
          mem_we      = g_we && !g_oob;
          mem_addr    = g_oob ? '0 : g_addr;
          mem_wdata   = (g_we && !g_oob) ? g_wdata : '0;
          g_pend_next = !g_we;
          g_oob_next  = g_oob;
        end else if (d_req) begin
          d_gnt       = 1'b1;
          rr_ptr_next = 1'b0;
          oob_err     = d_oob;
          mem_en      = !d_oob;
          mem_addr    = d_oob ? '0 : d_addr;
          d_pend_next = 1'b1;
          d_oob_next  = d_oob;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      rr_ptr_reg  <= 1'b0;
      g_pend_reg  <= 1'b0;
      g_oob_reg   <= 1'b0;
      d_pend_reg  <= 1'b0;
      d_oob_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      rr_ptr_reg  <= rr_ptr_next;
      g_pend_reg  <= g_pend_next;
      g_oob_reg   <= g_oob_next;
      d_pend_reg  <= d_pend_next;
      d_oob_reg   <= d_oob_next;
    end
  end

  // An out-of-range read still completes, but with zero data instead of stale RAM output.
  assign clear_busy = (state_reg == CLEAR);
  assign g_rvalid   = g_pend_reg;
  assign g_rdata    = (g_pend_reg && !g_oob_reg) ? mem_rdata : '0;
  assign d_rvalid   = d_pend_reg;
  assign d_rdata    = (d_pend_reg && !d_oob_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_board_access_ctrl.sv
// Directed bench for board_access_ctrl with a small behavioural board RAM attached.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_board_access_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear_req;
  logic       clear_busy;
  logic       g_req, g_we;
  logic [3:0] g_x, g_y;
  logic [3:0] g_wdata;
  logic       g_gnt, g_rvalid;
  logic [3:0] g_rdata;
  logic       d_req;
  logic [3:0] d_x, d_y;
  logic       d_gnt, d_rvalid;
  logic [3:0] d_rdata;
  logic       oob_err;
  logic       mem_en, mem_we;
  logic [5:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  logic [3:0] ram [64];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  board_access_ctrl #(
    .WIDTH(8), .HEIGHT(8), .BUS_W(4), .XW(4), .YW(4), .AW(6)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .g_req(g_req), .g_we(g_we), .g_x(g_x), .g_y(g_y), .g_wdata(g_wdata),
    .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
    .d_req(d_req), .d_x(d_x), .d_y(d_y),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .oob_err(oob_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Full 64-cell sweep starting this cycle; optionally pulses clear_req mid-sweep.
  task automatic sweep(input int pulse_at);
    for (int i = 0; i < 64; i++) begin
      if (i == pulse_at) clear_req = 1'b1;
      mid();
      chk($sformatf("sweep_addr%0d", i), 32'(mem_addr), i);
      chk("sweep_en_we", {30'd0, mem_en, mem_we}, 32'd3);
      chk("sweep_wdata", 32'(mem_wdata), 0);
      chk("sweep_busy", 32'(clear_busy), 1);
      chk("sweep_nognt", {30'd0, g_gnt, d_gnt}, 0);
      cyc();
      clear_req = 1'b0;
    end
    mid();
    chk("sweep_done_busy", 32'(clear_busy), 0);
  endtask

  initial begin
    reset_n = 1'b0; clear_req = 1'b0;
    g_req = 1'b0; g_we = 1'b0; g_x = '0; g_y = '0; g_wdata = '0;
    d_req = 1'b0; d_x = '0; d_y = '0;

    // 1: reset defaults and power-up sweep
    cyc(); cyc();
    mid();
    chk("rst_busy", 32'(clear_busy), 1);
    chk("rst_mem", {29'd0, mem_en, mem_we, oob_err}, 0);
    chk("rst_gnt_rv", {28'd0, g_gnt, d_gnt, g_rvalid, d_rvalid}, 0);
    cyc();
    reset_n = 1'b1;
    sweep(-1);
    chk("idle_mem_en", 32'(mem_en), 0);

    // 2: game write (2,3)=A then read back
    cyc();
    g_req = 1'b1; g_we = 1'b1; g_x = 4'd2; g_y = 4'd3; g_wdata = 4'hA;
    mid();
    chk("gw_gnt", {30'd0, g_gnt, d_gnt}, 32'd2);
    chk("gw_mem", {30'd0, mem_en, mem_we}, 32'd3);
    chk("gw_addr", 32'(mem_addr), 26);
    chk("gw_wdata", 32'(mem_wdata), 32'hA);
    cyc();
    g_we = 1'b0;
    mid();
    chk("gr_gnt", 32'(g_gnt), 1);
    chk("gr_mem", {30'd0, mem_en, mem_we}, 32'd2);
    chk("gr_addr", 32'(mem_addr), 26);
    chk("gr_norv", 32'(g_rvalid), 0);
    cyc();
    g_req = 1'b0;
    mid();
    chk("gr_rvalid", 32'(g_rvalid), 1);
    chk("gr_rdata", 32'(g_rdata), 32'hA);
    chk("gr_d_rvalid", 32'(d_rvalid), 0);
    cyc();
    mid();
    chk("gr_rv_gone", {28'd0, g_rvalid, g_rdata}, 0);

    // display read of the same cell hands priority back to game
    cyc();
    d_req = 1'b1; d_x = 4'd2; d_y = 4'd3;
    mid();
    chk("dr_gnt", {30'd0, g_gnt, d_gnt}, 32'd1);
    chk("dr_addr", 32'(mem_addr), 26);
    cyc();
    d_req = 1'b0;
    mid();
    chk("dr_rvalid", {30'd0, g_rvalid, d_rvalid}, 32'd1);
    chk("dr_rdata", 32'(d_rdata), 32'hA);

    // 3: both requesting for 6 cycles -> g,d,g,d,g,d
    cyc();
    g_req = 1'b1; g_we = 1'b0; g_x = 4'd1; g_y = 4'd0;
    d_req = 1'b1; d_x = 4'd2; d_y = 4'd3;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk($sformatf("rr_gnt%0d", i), {30'd0, g_gnt, d_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("rr_mem_en", 32'(mem_en), 1);
      chk("rr_addr", 32'(mem_addr), (i % 2 == 0) ? 32'd1 : 32'd26);
      cyc();
    end
    g_req = 1'b0; d_req = 1'b0;

    // 4: out-of-range read, then out-of-range write
    g_req = 1'b1; g_we = 1'b0; g_x = 4'd9; g_y = 4'd0;
    mid();
    chk("oobr_gnt", 32'(g_gnt), 1);
    chk("oobr_mem_en", 32'(mem_en), 0);
    chk("oobr_err", 32'(oob_err), 1);
    cyc();
    g_req = 1'b0;
    mid();
    chk("oobr_rvalid", 32'(g_rvalid), 1);
    chk("oobr_rdata", 32'(g_rdata), 0);
    chk("oobr_err_gone", 32'(oob_err), 0);
    cyc();
    g_req = 1'b1; g_we = 1'b1; g_x = 4'd0; g_y = 4'd9; g_wdata = 4'hF;
    mid();
    chk("oobw_gnt", 32'(g_gnt), 1);
    chk("oobw_mem", {30'd0, mem_en, mem_we}, 0);
    chk("oobw_err", 32'(oob_err), 1);
    cyc();
    g_req = 1'b0; g_we = 1'b0;
    mid();
    chk("oobw_norv", 32'(g_rvalid), 0);

    // 5: clear_req while display waits; mid-sweep clear_req ignored
    cyc();
    d_req = 1'b1; d_x = 4'd2; d_y = 4'd3; clear_req = 1'b1;
    mid();
    chk("clr_nognt", {30'd0, g_gnt, d_gnt}, 0);
    chk("clr_mem_en", 32'(mem_en), 0);
    cyc();
    clear_req = 1'b0;
    sweep(10);
    chk("clr_dgnt", 32'(d_gnt), 1);
    chk("clr_daddr", 32'(mem_addr), 26);
    cyc();
    d_req = 1'b0;
    mid();
    chk("clr_rvalid", 32'(d_rvalid), 1);
    chk("clr_rdata", 32'(d_rdata), 0);

    // 6: reset at sweep cycle 20 restarts a full sweep
    cyc();
    clear_req = 1'b1;
    mid();
    chk("rs_nogrant", 32'(mem_en), 0);
    cyc();
    clear_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid();
      chk("rs_addr", 32'(mem_addr), i);
      cyc();
    end
    reset_n = 1'b0;
    #1;
    chk("rs_mem", {29'd0, mem_en, mem_we, oob_err}, 0);
    chk("rs_addr0", 32'(mem_addr), 0);
    chk("rs_busy", 32'(clear_busy), 1);
    cyc(); cyc();
    reset_n = 1'b1;
    sweep(-1);

    // 7: reset while a read result is pending drops rvalid
    cyc();
    g_req = 1'b1; g_we = 1'b0; g_x = 4'd2; g_y = 4'd3;
    mid();
    chk("pr_gnt", 32'(g_gnt), 1);
    cyc();
    g_req = 1'b0;
    chk("pr_rvalid", 32'(g_rvalid), 1);
    reset_n = 1'b0;
    #1;
    chk("pr_rv_drop", {27'd0, g_rvalid, g_rdata}, 0);
    cyc();
    reset_n = 1'b1;
    mid();
    chk("pr_restart", {26'd0, clear_busy, mem_addr}, 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
